array_edit_engine: RTL and testbench
====================================

ARRAY_EDIT_ENGINE -- requirements
Module: array_edit_engine

Interface
REQ-001 The block SHALL have parameter N_SLOTS, default 6, number of editable slots (2..16).
REQ-002 The block SHALL have parameter VAL_W, default 3, slot value width in bits (2..8).
REQ-003 The block SHALL have parameter MAX_VAL, default 2**VAL_W-1, largest legal slot value, constrained to 2**(VAL_W-1) .. 2**VAL_W-1.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-005 The block SHALL have port clk_100mhz  input  1  sole clock, all state on rising edge.
REQ-006 The block SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port enable  input  1  edit mode active.
REQ-008 The block SHALL have ports inc_pulse, dec_pulse, right_pulse, left_pulse, grab_pulse, rand_pulse, clear_pulse  input  1 each  single-cycle command pulses.
REQ-009 The block SHALL have port commit_req  input  1  level request to publish the array.
REQ-010 The block SHALL have port array_flat  output  N_SLOTS*VAL_W  slot k at bits [k*VAL_W +: VAL_W].
REQ-011 The block SHALL have port cursor_pos  output  $clog2(N_SLOTS)  highlighted slot index.
REQ-012 The block SHALL have ports grabbed, busy, commit_valid, edited  output  1 each  grab mode, fill in progress, publish strobe, unpublished changes.

Function
REQ-013 The FSM SHALL have states IDLE, FILL, ACK; it leaves IDLE only to FILL (rand_pulse) or ACK (commit).
REQ-014 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle regardless of state or enable.
REQ-015 Rising edge of enable (registered previous value 0, current 1) SHALL zero all slots, cursor_pos, grabbed and edited, overriding every command that cycle.
REQ-016 While enable=0, all commands SHALL be ignored, grabbed SHALL clear, and the FSM SHALL return to IDLE, aborting any fill; slots keep their values.
REQ-017 In IDLE, at most one command SHALL act per cycle, priority clear > rand > grab > inc > dec > right > left.
REQ-018 clear_pulse SHALL zero all slots, cursor_pos and grabbed next cycle and set edited.
REQ-019 rand_pulse SHALL enter FILL with busy=1 and an internal index of 0, clear grabbed, and write one slot per cycle for N_SLOTS cycles, slot 0 first.
REQ-020 Fill value = LFSR[VAL_W-1:0], minus (MAX_VAL+1) if it exceeds MAX_VAL; the result SHALL always be <= MAX_VAL.
REQ-021 After the last slot is written the FSM SHALL return to IDLE with busy=0 the next cycle and edited set; commands arriving during FILL SHALL be dropped.
REQ-022 grab_pulse SHALL toggle grabbed.
REQ-023 Ungrabbed: inc/dec SHALL modify slot[cursor_pos] modulo MAX_VAL+1 (MAX_VAL+1 -> 0; 0-1 -> MAX_VAL) and set edited; right/left SHALL move the cursor with wrap (N_SLOTS-1 <-> 0).
REQ-024 Grabbed: right/left SHALL swap slot[cursor_pos] with its neighbour and move cursor_pos with it in the same cycle, and set edited; at index 0 (left) or N_SLOTS-1 (right) it SHALL be a no-op with no wrap; inc/dec SHALL be ignored.
REQ-025 commit_req=1 in IDLE with grabbed=0 and no command that cycle SHALL move the FSM to ACK, assert commit_valid for exactly one cycle (the cycle after sampling), and clear edited.
REQ-026 In ACK all commands SHALL be ignored; the FSM returns to IDLE only when commit_req=0, so one commit_valid is produced per request.
REQ-027 commit_req while grabbed=1 or busy=1 SHALL be held off until both are 0.
REQ-028 array_flat SHALL be stable throughout the cycle commit_valid=1.

Reset
REQ-029 reset=0 SHALL immediately set all slots to 0, cursor_pos 0, grabbed 0, busy 0, commit_valid 0, edited 0, LFSR to LFSR_SEED, FSM to IDLE, and the registered enable to 0.
REQ-030 Reset asserted mid-FILL or in ACK SHALL abort the operation with no further slot writes.
REQ-031 Deassertion SHALL take effect synchronously on the next rising edge; a first enable=1 after reset counts as a rising edge.

Verification
REQ-032 Defaults: reset, enable high, cursor 0, 8 inc_pulse -> slot0 wraps 7->0 and ends 0; one dec -> 7; edited=1.
REQ-033 Defaults: 5 left_pulse ungrabbed from 0 -> cursor 1; right from 5 -> 0.
REQ-034 Slots [3,1,0,0,0,0], cursor 0, grab, right, right -> slots [1,0,3,0,0,0], cursor 2; grab, left at 0 -> unchanged.
REQ-035 MAX_VAL=5, VAL_W=3: rand_pulse -> busy high exactly 6 cycles, every slot <= 5, inc_pulse during FILL dropped.
REQ-036 commit_req held 10 cycles in IDLE -> single commit_valid pulse, edited 0; with grabbed=1 -> none until grab toggled off.
REQ-037 reset pulsed low at fill cycle 3 -> all slots 0, busy 0; enable 0->1 with edited slots -> all zero next cycle.

Source files
------------

// File: rtl/array_edit_engine.sv
// Slot-array editor: cursor/grab editing, LFSR random fill (one slot per cycle), and commit handshake.
// All outputs registered; commands are single-cycle pulses and are dropped when the FSM is not IDLE.
module array_edit_engine #(
  parameter int          N_SLOTS   = 6,
  parameter int          VAL_W     = 3,
  parameter int          MAX_VAL   = 2**VAL_W-1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk_100mhz,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inc_pulse,
  input  logic                       dec_pulse,
  input  logic                       right_pulse,
  input  logic                       left_pulse,
  input  logic                       grab_pulse,
  input  logic                       rand_pulse,
  input  logic                       clear_pulse,
  input  logic                       commit_req,
  output logic [N_SLOTS*VAL_W-1:0]   array_flat,
  output logic [$clog2(N_SLOTS)-1:0] cursor_pos,
  output logic                       grabbed,
  output logic                       busy,
  output logic                       commit_valid,
  output logic                       edited
);
  localparam int             CW    = $clog2(N_SLOTS);
  localparam logic [CW-1:0]  LAST  = CW'(N_SLOTS - 1);
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, FILL, ACK} state_t;

  state_t           state_q, state_d;
  logic [VAL_W-1:0] slot_q [N_SLOTS];
  logic [VAL_W-1:0] slot_d [N_SLOTS];
  logic [CW-1:0]    cursor_q, cursor_d, fill_idx_q, fill_idx_d;
  logic             grabbed_q, grabbed_d, edited_q, edited_d;
  logic             commit_valid_q, commit_valid_d, en_q, en_d;
  logic [15:0]      lfsr_q, lfsr_d;

  logic             en_rise, idle_act, cmd_any, commit_go;
  logic [CW-1:0]    cur_inc, cur_dec;
  logic [VAL_W-1:0] fill_raw, fill_val;

  assign en_rise   = enable & ~en_q;
  assign idle_act  = enable & ~en_rise & (state_q == IDLE);
  assign cmd_any   = clear_pulse | rand_pulse | grab_pulse | inc_pulse |
                     dec_pulse | right_pulse | left_pulse;
  assign commit_go = idle_act & commit_req & ~grabbed_q & ~cmd_any;
  assign cur_inc   = cursor_q + 1'b1;
  assign cur_dec   = cursor_q - 1'b1;
  // Raw LFSR bits can exceed MAX_VAL by at most MAX_VAL+1, so one subtraction folds them back.
  assign fill_raw  = lfsr_q[VAL_W-1:0];
  assign fill_val  = (fill_raw > MAX_V) ? fill_raw - (MAX_V + 1'b1) : fill_raw;

  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cursor_q       <= '0;
      fill_idx_q     <= '0;
      grabbed_q      <= 1'b0;
      edited_q       <= 1'b0;
      commit_valid_q <= 1'b0;
      en_q           <= 1'b0;
      lfsr_q         <= LFSR_SEED;
      for (int k = 0; k < N_SLOTS; k++) slot_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      cursor_q       <= cursor_d;
      fill_idx_q     <= fill_idx_d;
      grabbed_q      <= grabbed_d;
      edited_q       <= edited_d;
      commit_valid_q <= commit_valid_d;
      en_q           <= en_d;
      lfsr_q         <= lfsr_d;
      for (int k = 0; k < N_SLOTS; k++) slot_q[k] <= slot_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable || en_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!clear_pulse && rand_pulse) state_d = FILL;
          else if (commit_go)             state_d = ACK;
        end
        FILL:    if (fill_idx_q == LAST) state_d = IDLE;
        ACK:     if (!commit_req)        state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) slot_d[k] = slot_q[k];
    cursor_d       = cursor_q;
    fill_idx_d     = fill_idx_q;
    grabbed_d      = grabbed_q;
    edited_d       = edited_q;
    commit_valid_d = commit_go;
    en_d           = enable;
    lfsr_d         = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    if (en_rise) begin
      for (int k = 0; k < N_SLOTS; k++) slot_d[k] = '0;
      cursor_d  = '0;
      grabbed_d = 1'b0;
      edited_d  = 1'b0;
    end else if (!enable) begin
      grabbed_d = 1'b0;
    end else if (state_q == FILL) begin
      slot_d[fill_idx_q] = fill_val;
      fill_idx_d         = fill_idx_q + 1'b1;
      if (fill_idx_q == LAST) edited_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (clear_pulse) begin
        for (int k = 0; k < N_SLOTS; k++) slot_d[k] = '0;
        cursor_d  = '0;
        grabbed_d = 1'b0;
        edited_d  = 1'b1;
      end else if (rand_pulse) begin
        fill_idx_d = '0;
        grabbed_d  = 1'b0;
      end else if (grab_pulse) begin
        grabbed_d = ~grabbed_q;
      end else if (inc_pulse) begin
        if (!grabbed_q) begin
          slot_d[cursor_q] = (slot_q[cursor_q] == MAX_V) ? '0 : slot_q[cursor_q] + 1'b1;
          edited_d         = 1'b1;
        end
      end else if (dec_pulse) begin
        if (!grabbed_q) begin
          slot_d[cursor_q] = (slot_q[cursor_q] == '0) ? MAX_V : slot_q[cursor_q] - 1'b1;
          edited_d         = 1'b1;
        end
      end else if (right_pulse) begin
        if (!grabbed_q) begin
          cursor_d = (cursor_q == LAST) ? '0 : cur_inc;
        end else if (cursor_q != LAST) begin
          slot_d[cursor_q] = slot_q[cur_inc];
          slot_d[cur_inc]  = slot_q[cursor_q];
          cursor_d         = cur_inc;
          edited_d         = 1'b1;
        end
      end else if (left_pulse) begin
        if (!grabbed_q) begin
          cursor_d = (cursor_q == '0) ? LAST : cur_dec;
        end else if (cursor_q != '0) begin
          slot_d[cursor_q] = slot_q[cur_dec];
          slot_d[cur_dec]  = slot_q[cursor_q];
          cursor_d         = cur_dec;
          edited_d         = 1'b1;
        end
      end else if (commit_go) begin
        edited_d = 1'b0;
      end
    end
  end

  always_comb begin
    busy         = (state_q == FILL);
    cursor_pos   = cursor_q;
    grabbed      = grabbed_q;
    edited       = edited_q;
    commit_valid = commit_valid_q;
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_flat
    assign array_flat[k*VAL_W +: VAL_W] = slot_q[k];
  end

endmodule

// File: tb/tb_array_edit_engine.sv
// Bench for array_edit_engine: per-cycle scoreboard against a rule-level model plus a commit queue.
module tb_array_edit_engine;
  localparam int N = 6;
  localparam int W = 3;
  localparam int MAXV = 7;
  localparam int B_CLR = 6, B_RND = 5, B_GRB = 4, B_INC = 3, B_DEC = 2, B_RGT = 1, B_LFT = 0;
  localparam int M_IDLE = 0, M_FILL = 1, M_ACK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic commit_req = 1'b0;
  logic [6:0] cmd = '0;

  logic [N*W-1:0] array_flat, array_flat5;
  logic [2:0] cursor_pos, cursor_pos5;
  logic grabbed, busy, commit_valid, edited;
  logic grabbed5, busy5, commit_valid5, edited5;

  always #5 clk = ~clk;

  array_edit_engine dut (
    .clk_100mhz(clk), .reset(rst_n), .enable(enable),
    .inc_pulse(cmd[B_INC]), .dec_pulse(cmd[B_DEC]), .right_pulse(cmd[B_RGT]),
    .left_pulse(cmd[B_LFT]), .grab_pulse(cmd[B_GRB]), .rand_pulse(cmd[B_RND]),
    .clear_pulse(cmd[B_CLR]), .commit_req(commit_req),
    .array_flat(array_flat), .cursor_pos(cursor_pos), .grabbed(grabbed),
    .busy(busy), .commit_valid(commit_valid), .edited(edited)
  );

  array_edit_engine #(.MAX_VAL(5)) dut5 (
    .clk_100mhz(clk), .reset(rst_n), .enable(enable),
    .inc_pulse(cmd[B_INC]), .dec_pulse(cmd[B_DEC]), .right_pulse(cmd[B_RGT]),
    .left_pulse(cmd[B_LFT]), .grab_pulse(cmd[B_GRB]), .rand_pulse(cmd[B_RND]),
    .clear_pulse(cmd[B_CLR]), .commit_req(commit_req),
    .array_flat(array_flat5), .cursor_pos(cursor_pos5), .grabbed(grabbed5),
    .busy(busy5), .commit_valid(commit_valid5), .edited(edited5)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: slot array as plain ints, updated once per rising edge.
  int m_slot [N];
  int m_cur, m_mode, m_idx;
  bit m_grab, m_ed, m_cv, m_enp;
  logic [15:0] m_lfsr;

  typedef struct {
    logic [N*W-1:0] arr;
    int cur;
    bit grab, busy, cv, ed;
  } snap_t;
  snap_t snap_q[$];
  logic [N*W-1:0] commit_q[$];

  function automatic logic [N*W-1:0] pack_model();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(m_slot[k]);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_slot[k] = 0;
    m_cur = 0; m_mode = M_IDLE; m_idx = 0;
    m_grab = 0; m_ed = 0; m_cv = 0; m_enp = 0;
    m_lfsr = 16'hACE1;
    commit_q.delete();
  endtask

  task automatic swap(input int a, input int b);
    int t;
    t = m_slot[a]; m_slot[a] = m_slot[b]; m_slot[b] = t;
  endtask

  task automatic model_step();
    logic [15:0] nl;
    int v;
    m_cv = 0;
    nl = m_lfsr >> 1;
    if (m_lfsr % 2 == 1) nl = nl ^ 16'hB400;
    if (enable && !m_enp) begin
      for (int k = 0; k < N; k++) m_slot[k] = 0;
      m_cur = 0; m_grab = 0; m_ed = 0; m_mode = M_IDLE;
    end else if (!enable) begin
      m_grab = 0; m_mode = M_IDLE;
    end else if (m_mode == M_FILL) begin
      v = int'(m_lfsr) % (1 << W);
      if (v > MAXV) v = v - (MAXV + 1);
      m_slot[m_idx] = v;
      m_idx++;
      if (m_idx == N) begin m_mode = M_IDLE; m_ed = 1; end
    end else if (m_mode == M_ACK) begin
      if (!commit_req) m_mode = M_IDLE;
    end else begin
      if (cmd[B_CLR]) begin
        for (int k = 0; k < N; k++) m_slot[k] = 0;
        m_cur = 0; m_grab = 0; m_ed = 1;
      end else if (cmd[B_RND]) begin
        m_mode = M_FILL; m_idx = 0; m_grab = 0;
      end else if (cmd[B_GRB]) begin
        m_grab = !m_grab;
      end else if (cmd[B_INC]) begin
        if (!m_grab) begin m_slot[m_cur] = (m_slot[m_cur] + 1) % (MAXV + 1); m_ed = 1; end
      end else if (cmd[B_DEC]) begin
        if (!m_grab) begin m_slot[m_cur] = (m_slot[m_cur] + MAXV) % (MAXV + 1); m_ed = 1; end
      end else if (cmd[B_RGT]) begin
        if (!m_grab) m_cur = (m_cur + 1) % N;
        else if (m_cur < N - 1) begin swap(m_cur, m_cur + 1); m_cur++; m_ed = 1; end
      end else if (cmd[B_LFT]) begin
        if (!m_grab) m_cur = (m_cur + N - 1) % N;
        else if (m_cur > 0) begin swap(m_cur, m_cur - 1); m_cur--; m_ed = 1; end
      end else if (commit_req && !m_grab) begin
        m_mode = M_ACK; m_cv = 1; m_ed = 0;
        commit_q.push_back(pack_model());
      end
    end
    m_enp = enable;
    m_lfsr = nl;
  endtask

  always @(posedge clk) begin
    snap_t s;
    if (!rst_n) model_reset();
    else model_step();
    s.arr = pack_model(); s.cur = m_cur; s.grab = m_grab;
    s.busy = (m_mode == M_FILL); s.cv = m_cv; s.ed = m_ed;
    snap_q.push_back(s);
  end

  // Monitor: compares DUT outputs against the oldest expected snapshot each cycle.
  always @(negedge clk) begin
    snap_t s;
    bit in_range;
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      if (!rst_n) begin
        chk("reset_array", array_flat, 0);
        chk("reset_cursor", cursor_pos, 0);
        chk("reset_grabbed", grabbed, 0);
        chk("reset_busy", busy, 0);
        chk("reset_commit_valid", commit_valid, 0);
        chk("reset_edited", edited, 0);
      end else begin
        chk("array", array_flat, s.arr);
        chk("cursor", cursor_pos, s.cur);
        chk("grabbed", grabbed, s.grab);
        chk("busy", busy, s.busy);
        chk("commit_valid", commit_valid, s.cv);
        chk("edited", edited, s.ed);
      end
    end
    if (rst_n && commit_valid === 1'b1) begin
      chk("commit_expected", commit_q.size() > 0, 1);
      if (commit_q.size() > 0) chk("commit_array", array_flat, commit_q.pop_front());
    end
    if (rst_n) begin
      in_range = 1;
      for (int k = 0; k < N; k++) if (array_flat5[k*W +: W] > 3'd5) in_range = 0;
      chk("max5_slot_range", in_range, 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int b);
    cmd = '0;
    cmd[b] = 1'b1;
    cyc(1);
    cmd = '0;
  endtask

  initial begin
    int cnt, cnt5;
    logic [6:0] c;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    enable = 1'b1;
    cyc(2);
    chk("start_array", array_flat, 0);
    chk("start_cursor", cursor_pos, 0);

    // Increment wrap and decrement wrap on slot 0.
    repeat (8) pulse(B_INC);
    chk("inc8_slot0", array_flat[2:0], 0);
    chk("inc8_edited", edited, 1);
    pulse(B_DEC);
    chk("dec_slot0", array_flat[2:0], 7);

    // Cursor wrap both ways.
    repeat (5) pulse(B_LFT);
    chk("left5_cursor", cursor_pos, 1);
    repeat (4) pulse(B_RGT);
    chk("cursor_at_5", cursor_pos, 5);
    pulse(B_RGT);
    chk("right_wrap_cursor", cursor_pos, 0);

    // Grabbed swaps: [3,1,0,0,0,0] -> [1,0,3,0,0,0].
    pulse(B_CLR);
    repeat (3) pulse(B_INC);
    pulse(B_RGT);
    pulse(B_INC);
    pulse(B_LFT);
    pulse(B_GRB);
    pulse(B_RGT);
    pulse(B_RGT);
    chk("swap_array", array_flat, 18'h000C1);
    chk("swap_cursor", cursor_pos, 2);
    pulse(B_GRB);
    repeat (2) pulse(B_LFT);
    pulse(B_GRB);
    pulse(B_LFT);
    chk("edge_left_array", array_flat, 18'h000C1);
    chk("edge_left_cursor", cursor_pos, 0);
    pulse(B_GRB);

    // Random fill: busy exactly N cycles, inc during fill dropped.
    pulse(B_RND);
    cnt = 0; cnt5 = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) cnt++;
      if (busy5) cnt5++;
      cmd = '0;
      if (i == 2) cmd[B_INC] = 1'b1;
      cyc(1);
    end
    cmd = '0;
    chk("fill_busy_cycles", cnt, 6);
    chk("fill_busy_cycles_max5", cnt5, 6);
    chk("fill_edited", edited, 1);

    // Commit held for 10 cycles gives one pulse.
    commit_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (commit_valid) cnt++; end
    chk("commit_pulse_count", cnt, 1);
    chk("commit_edited_cleared", edited, 0);
    commit_req = 1'b0;
    cyc(2);
    pulse(B_GRB);
    commit_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin cyc(1); if (commit_valid) cnt++; end
    chk("commit_held_while_grabbed", cnt, 0);
    pulse(B_GRB);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin if (commit_valid) cnt++; cyc(1); end
    chk("commit_after_ungrab", cnt, 1);
    commit_req = 1'b0;
    cyc(2);

    // Reset in the middle of a fill.
    pulse(B_RND);
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("midfill_reset_array", array_flat, 0);
    chk("midfill_reset_busy", busy, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    repeat (2) pulse(B_INC);
    chk("post_reset_edit", array_flat[2:0], 2);
    enable = 1'b0;
    cyc(2);
    chk("disabled_keeps_slots", array_flat[2:0], 2);
    enable = 1'b1;
    cyc(1);
    chk("enable_rise_array", array_flat, 0);
    chk("enable_rise_edited", edited, 0);

    // Randomized traffic, checked entirely by the monitor.
    for (int i = 0; i < 3000; i++) begin
      c = '0;
      for (int b = 0; b < 7; b++) if ($urandom_range(0, 9) == 0) c[b] = 1'b1;
      if (c[B_RND] && $urandom_range(0, 2) != 0) c[B_RND] = 1'b0;
      cmd = c;
      if ($urandom_range(0, 9) == 0) commit_req = ~commit_req;
      if (enable ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 3) == 0)) enable = ~enable;
      rst_n = ($urandom_range(0, 599) != 0);
      cyc(1);
    end
    cmd = '0;
    commit_req = 1'b0;
    rst_n = 1'b1;
    cyc(3);
    chk("commit_queue_drained", commit_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
